// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the producer-side hazard scoreboard: forward-select codes,
// the shadow-entry record and the youngest-writer forward picker.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned N_ENTRIES = 3;   // EX, MEM, WB in age order

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } shadow_entry_t;

    // hit[0] is the EX entry, hit[1] MEM, hit[2] WB. A WB writer lands in the
    // register file at the same edge the consumer enters EX, so it reads RF.
    function automatic fwd_sel_t fwd_pick(input logic [N_ENTRIES-1:0] hit);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (hit[0]) begin
            sel = FWD_EXMEM;
        end else if (hit[1]) begin
            sel = FWD_MEMWB;
        end else if (hit[2]) begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: decoded source/destination fields in, stall and
// forwarding selects out.
interface hazard_scoreboard_if #(
    parameter int unsigned CNT_W = 16
);
    import hazard_scoreboard_pkg::*;

    logic             ID_Valid;
    logic [REG_W-1:0] ID_R1;
    logic [REG_W-1:0] ID_R2;
    logic             R1_Used;
    logic             R2_Used;
    logic [REG_W-1:0] ID_Rd;
    logic             ID_RegWrite;
    logic             ID_MemRead;
    logic             Flush;
    logic             Stall;
    logic [1:0]       Fwd_A;
    logic [1:0]       Fwd_B;
    logic [CNT_W-1:0] Stall_Count;

    modport master (
        output ID_Valid, ID_R1, ID_R2, R1_Used, R2_Used,
               ID_Rd, ID_RegWrite, ID_MemRead, Flush,
        input  Stall, Fwd_A, Fwd_B, Stall_Count
    );

    modport slave (
        input  ID_Valid, ID_R1, ID_R2, R1_Used, R2_Used,
               ID_Rd, ID_RegWrite, ID_MemRead, Flush,
        output Stall, Fwd_A, Fwd_B, Stall_Count
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Single source-vs-writer comparator; x0 never matches because it is never
// recorded as a valid destination.
module hazard_match
    import hazard_scoreboard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             used,
    input  shadow_entry_t    entry,
    output logic             match
);

    assign match = used & entry.v & (rs == entry.rd);

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow EX/MEM/WB writer pipeline producing the load-use stall, registered
// EX forwarding selects and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    hazard_scoreboard_if.slave bus
);

    shadow_entry_t    ex_q;
    shadow_entry_t    mem_q;
    shadow_entry_t    wb_q;
    shadow_entry_t    ex_d;
    shadow_entry_t    ent [N_ENTRIES];

    logic [N_ENTRIES-1:0] m1;
    logic [N_ENTRIES-1:0] m2;

    logic             stall;
    logic             issue;
    fwd_sel_t         fwd_a_q;
    fwd_sel_t         fwd_b_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        ent[0] = ex_q;
        ent[1] = mem_q;
        ent[2] = wb_q;
    end

    for (genvar i = 0; i < N_ENTRIES; i++) begin : g_match
        hazard_match u_m1 (
            .rs    (bus.ID_R1),
            .used  (bus.R1_Used),
            .entry (ent[i]),
            .match (m1[i])
        );
        hazard_match u_m2 (
            .rs    (bus.ID_R2),
            .used  (bus.R2_Used),
            .entry (ent[i]),
            .match (m2[i])
        );
    end

    // Flush wins over stall; the load leaves EX next edge so this lasts one cycle.
    assign stall = bus.ID_Valid & ~bus.Flush & ex_q.v & ex_q.ld & (m1[0] | m2[0]);
    assign issue = bus.ID_Valid & ~stall & ~bus.Flush;

    always_comb begin
        ex_d = '0;
        if (issue && bus.ID_RegWrite && (bus.ID_Rd != '0)) begin
            ex_d.v  = 1'b1;
            ex_d.rd = bus.ID_Rd;
            ex_d.ld = bus.ID_MemRead;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            if (issue) begin
                fwd_a_q <= fwd_pick(m1);
                fwd_b_q <= fwd_pick(m2);
            end else begin
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.Stall       = stall;
    assign bus.Fwd_A       = fwd_a_q;
    assign bus.Fwd_B       = fwd_b_q;
    assign bus.Stall_Count = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side hazard tracker for the five-stage interrupt pipeline. It is the write-side counterpart of the per-instruction source-register-use decoder. A three-entry shadow pipeline records the destination register of every in-flight writer in EX, MEM and WB. Each decoding instruction's used sources (rs1/rs2 plus their use flags) are compared against these entries to produce a load-use stall request and registered forwarding selects for the EX stage. The block sits beside the ID/EX pipeline register and advances with it.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- CLK  in  1  pipeline clock
- RST_N  in  1  asynchronous, active-low reset
- ID_Valid  in  1  ID holds a real instruction (not a bubble)
- ID_R1  in  5  rs1 field of the ID instruction
- ID_R2  in  5  rs2 field of the ID instruction
- R1_Used  in  1  ID instruction reads rs1
- R2_Used  in  1  ID instruction reads rs2
- ID_Rd  in  5  rd field of the ID instruction
- ID_RegWrite  in  1  ID instruction writes rd
- ID_MemRead  in  1  ID instruction is a load (lw/lbu)
- Flush  in  1  taken branch/jump, interrupt entry or uret; squashes ID
- Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational)
- Fwd_A  out  2  EX operand-A source: 00 register file, 01 EX/MEM, 10 MEM/WB (registered)
- Fwd_B  out  2  EX operand-B source, same encoding (registered)
- Stall_Count  out  CNT_W  number of load-use stall cycles, saturating

## Operation
- Shadow entries EX, MEM and WB, each {V, Rd[4:0], Ld}. Reset: all V=0, Rd=0, Ld=0.
- Issue qualifier: issue = ID_Valid & ~Stall & ~Flush.
- Every clock edge:
  - WB ← MEM
  - MEM ← EX
  - EX ← {1, ID_Rd, ID_MemRead} when issue & ID_RegWrite & (ID_Rd≠0); otherwise {0,0,0}
- Source match: m1(X) = R1_Used & X.V & (ID_R1==X.Rd); m2(X) likewise for rs2. Rd=0 never matches because it is never recorded.
- Stall = ID_Valid & ~Flush & EX.V & EX.Ld & (m1(EX) | m2(EX)). Flush overrides Stall.
- Forwarding selects are registered at the same edge as EX:
  - If not issue: Fwd_A and Fwd_B ← 00.
  - Else Fwd_A ← 01 if m1(EX) (that writer moves to MEM), else 10 if m1(MEM) (moves to WB), else 00.
  - Fwd_B follows the same rule with m2.
  - EX has priority over MEM, so the youngest writer wins.
- A WB-stage writer needs no forward. The register file writes at that edge.
- Stall_Count increments on every cycle Stall=1 and holds at all-ones.
- Reset values: Fwd_A=00, Fwd_B=00, Stall_Count=0, Stall=0 (no valid entries).

## Timing
- Stall is combinational from the ID inputs and EX entry, with zero latency. It is asserted for exactly one cycle per load-use pair, because the load leaves EX at the next edge.
- Fwd_A and Fwd_B have one-cycle latency. They are valid while the consumer occupies EX and are 00 during a bubble.
- Flush in the same cycle as a would-be stall:
  - No stall.
  - EX receives a bubble.
  - The older entries still advance; they are not squashed, because they belong to committed-path instructions.
- Back-to-back writers to the same rd: the EX match wins (01).
- Stall_Count saturating wrap is forbidden.
- RST_N low mid-operation clears all entries and outputs immediately (asynchronous). The first edge after release behaves as from an empty pipeline.

## Structure
- Shared package holds:
  - The forward-select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The shadow-entry struct {V, Rd, Ld}.
- Natural sub-module: hazard_match, a combinational comparator taking {rs, used, entry} and returning the match bit. It is instantiated six times (2 sources × 3 entries).

## Test plan
- Plain dependency: add x5 issues, then add x6,x5,x7 next cycle → Stall=0; Fwd_A=01 during the consumer's EX cycle and Fwd_B=00.
- Distance-2 dependency: add x5, nop, sub x8,x9,x5 → Fwd_B=10 in the sub's EX cycle.
- Load-use: lw x5, then add x6,x5,x5 in ID → Stall=1 for one cycle, Stall_Count=1; the add then enters EX with Fwd_A=Fwd_B=10.
- x0 writer: addi x0,x0,1 followed by a reader of x0 → no stall and Fwd=00.
- Flush during load-use (Flush=1 while lw x5 in EX and reader in ID) → Stall=0; the next EX entry V=0; Fwd=00.
- Assert RST_N=0 mid-stream with entries valid → entries cleared and Fwd=00 without a clock edge. Stall_Count saturates at 16'hFFFF under continuous load-use stimulus.
